// File: rtl/mem_stage_ext_if.sv
// Request/acknowledge bus between the memory stage (master) and an external,
// variable-latency word memory (slave).
interface mem_stage_ext_if #(
   parameter int WORD_WIDTH = 32,
   parameter int MEM_AW     = 16
);
   localparam int LANES = WORD_WIDTH / 8;

   logic                  req;
   logic                  we;
   logic [MEM_AW-1:0]     addr;
   logic [LANES-1:0]      be;
   logic [WORD_WIDTH-1:0] wdata;
   logic [WORD_WIDTH-1:0] rdata;
   logic                  ack;

   modport master (output req, we, addr, be, wdata, input rdata, ack);
   modport slave  (input req, we, addr, be, wdata, output rdata, ack);
endinterface

// File: rtl/mem_stage_ext.sv
// Pipeline memory stage driving an external variable-latency word memory with
// lane steering, sign extension, decode-error detection and optional timeout.
module mem_stage_ext #(
   parameter int          WORD_WIDTH     = 32,
   parameter int          REG_FILE_DEPTH = 4,
   parameter int          MEM_AW         = 16,
   parameter int unsigned BASE_ADDR      = 1024,
   parameter int          TIMEOUT        = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      mem_read,
   input  logic                      mem_write,
   input  logic                      WB_en,
   input  logic [1:0]                size,
   input  logic                      sign_ext,
   input  logic [REG_FILE_DEPTH-1:0] dst,
   input  logic [WORD_WIDTH-1:0]     ALU_res,
   input  logic [WORD_WIDTH-1:0]     val_Rm,
   output logic                      mem_read_out,
   output logic                      WB_en_out,
   output logic [REG_FILE_DEPTH-1:0] dst_out,
   output logic [WORD_WIDTH-1:0]     ALU_res_out,
   output logic [WORD_WIDTH-1:0]     mem_out,
   output logic                      freeze,
   output logic                      access_err,
   mem_stage_ext_if.master           ext
);
   localparam int LANES = WORD_WIDTH / 8;
   localparam int LB    = $clog2(LANES);
   localparam int OW    = WORD_WIDTH + MEM_AW + LB;
   localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]            state_reg;
   logic                  ext_req_reg;
   logic                  ext_we_reg;
   logic [MEM_AW-1:0]     ext_addr_reg;
   logic [LANES-1:0]      ext_be_reg;
   logic [WORD_WIDTH-1:0] ext_wdata_reg;
   logic [WORD_WIDTH-1:0] mem_out_reg;
   logic [LB-1:0]         lane_reg;
   logic [1:0]            size_reg;
   logic                  sign_reg;
   logic [TW-1:0]         tcnt_reg;
   logic                  tflag_reg;

   logic [OW-1:0]         off_wide;
   logic [LB-1:0]         lane;
   logic [MEM_AW-1:0]     word_addr;
   logic                  below_base;
   logic                  above_range;
   logic                  size_err;
   logic                  dec_err;
   logic                  is_access;
   logic                  start_access;
   logic                  decode_fault;
   logic [LANES-1:0]      be_next;
   logic [WORD_WIDTH-1:0] wdata_next;
   logic [WORD_WIDTH-1:0] rd_shift;
   logic [WORD_WIDTH-1:0] rd_steer;

   // Offset is computed wide so the range check sees every bit above the window.
   assign off_wide    = OW'(ALU_res) - OW'(BASE_ADDR);
   assign below_base  = ALU_res < WORD_WIDTH'(BASE_ADDR);
   assign above_range = |(off_wide >> (MEM_AW + LB));
   assign lane        = off_wide[LB-1:0];
   assign word_addr   = off_wide[MEM_AW+LB-1:LB];

   always_comb begin
      case (size)
         2'b00:   size_err = 1'b0;
         2'b01:   size_err = lane[0];
         2'b10:   size_err = |lane;
         default: size_err = 1'b1;
      endcase
   end

   assign dec_err      = below_base | above_range | size_err;
   assign is_access    = mem_read | mem_write;
   assign start_access = (state_reg == S_IDLE) & is_access & ~dec_err;
   assign decode_fault = (state_reg == S_IDLE) & is_access & dec_err;

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign be_next[gi] = (size == 2'b10) ||
                              (size == 2'b00 && lane == LB'(gi)) ||
                              (size == 2'b01 && (lane >> 1) == LB'(gi / 2));
         assign wdata_next[gi*8 +: 8] = (size == 2'b00) ? val_Rm[7:0] :
                                        (size == 2'b01) ? val_Rm[(gi % 2)*8 +: 8] :
                                                          val_Rm[gi*8 +: 8];
      end
   endgenerate

   // Steering uses the lane/size latched at request time, not the live inputs.
   assign rd_shift = ext.rdata >> {lane_reg, 3'b000};

   always_comb begin
      rd_steer = rd_shift;
      case (size_reg)
         2'b00: begin
            rd_steer      = {WORD_WIDTH{sign_reg & rd_shift[7]}};
            rd_steer[7:0] = rd_shift[7:0];
         end
         2'b01: begin
            rd_steer       = {WORD_WIDTH{sign_reg & rd_shift[15]}};
            rd_steer[15:0] = rd_shift[15:0];
         end
         default: rd_steer = rd_shift;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= S_IDLE;
         ext_req_reg   <= 1'b0;
         ext_we_reg    <= 1'b0;
         ext_addr_reg  <= '0;
         ext_be_reg    <= '0;
         ext_wdata_reg <= '0;
         mem_out_reg   <= '0;
         lane_reg      <= '0;
         size_reg      <= 2'b00;
         sign_reg      <= 1'b0;
         tcnt_reg      <= '0;
         tflag_reg     <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start_access) begin
                  state_reg     <= S_BUSY;
                  ext_req_reg   <= 1'b1;
                  ext_we_reg    <= mem_write;
                  ext_addr_reg  <= word_addr;
                  ext_be_reg    <= be_next;
                  ext_wdata_reg <= wdata_next;
                  lane_reg      <= lane;
                  size_reg      <= size;
                  sign_reg      <= sign_ext;
                  tcnt_reg      <= '0;
               end
            end
            S_BUSY: begin
               // An ack on the final allowed cycle takes priority over the timeout.
               if (ext.ack) begin
                  ext_req_reg <= 1'b0;
                  state_reg   <= S_DONE;
                  if (!ext_we_reg) begin
                     mem_out_reg <= rd_steer;
                  end
               end else if (TIMEOUT > 0 && tcnt_reg == TW'(TIMEOUT - 1)) begin
                  ext_req_reg <= 1'b0;
                  mem_out_reg <= '0;
                  tflag_reg   <= 1'b1;
                  state_reg   <= S_DONE;
               end else begin
                  tcnt_reg <= tcnt_reg + 1'b1;
               end
            end
            S_DONE: begin
               state_reg <= S_IDLE;
               tflag_reg <= 1'b0;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign freeze     = rst & (start_access | (state_reg == S_BUSY));
   assign access_err = rst & (decode_fault | ((state_reg == S_DONE) & tflag_reg));

   assign WB_en_out    = WB_en & ~freeze & ~access_err;
   assign mem_read_out = mem_read & ~freeze & ~access_err;
   assign dst_out      = dst;
   assign ALU_res_out  = ALU_res;
   assign mem_out      = mem_out_reg;

   assign ext.req   = ext_req_reg;
   assign ext.we    = ext_we_reg;
   assign ext.addr  = ext_addr_reg;
   assign ext.be    = ext_be_reg;
   assign ext.wdata = ext_wdata_reg;
endmodule

// File: tb/tb_mem_stage_ext.sv
// Randomized scoreboard bench for mem_stage_ext against a byte-addressed memory model.
module tb_mem_stage_ext;
   localparam int          WW   = 32;
   localparam int          RD   = 4;
   localparam int          AW   = 16;
   localparam int          TO   = 4;
   localparam int unsigned BASE = 1024;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          mem_read = 1'b0, mem_write = 1'b0, WB_en = 1'b0, sign_ext = 1'b0;
   logic [1:0]    size = 2'b00;
   logic [RD-1:0] dst = '0;
   logic [WW-1:0] ALU_res = '0, val_Rm = '0;
   logic          mem_read_out, WB_en_out, freeze, access_err;
   logic [RD-1:0] dst_out;
   logic [WW-1:0] ALU_res_out, mem_out;

   mem_stage_ext_if #(.WORD_WIDTH(WW), .MEM_AW(AW)) ext ();

   mem_stage_ext #(
      .WORD_WIDTH(WW), .REG_FILE_DEPTH(RD), .MEM_AW(AW), .BASE_ADDR(BASE), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .WB_en(WB_en),
      .size(size), .sign_ext(sign_ext), .dst(dst), .ALU_res(ALU_res), .val_Rm(val_Rm),
      .mem_read_out(mem_read_out), .WB_en_out(WB_en_out), .dst_out(dst_out),
      .ALU_res_out(ALU_res_out), .mem_out(mem_out), .freeze(freeze),
      .access_err(access_err), .ext(ext)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          valid, err, wb, mrd, we;
      logic [WW-1:0] mem_out, wdata, alu;
      logic [AW-1:0] addr;
      logic [3:0]    be;
      logic [RD-1:0] dst;
      int            stall, reqc;
   } exp_t;

   exp_t          sb_q[$];
   int            vectors = 0, miscompares = 0;
   int            retire_cnt = 0, ack_delay = 1;
   bit            mon_en = 1'b0, force_ack = 1'b0, unstable = 1'b0;
   logic [7:0]    model_mem[int];
   logic [31:0]   resp_mem[int];
   logic [31:0]   model_mem_out = '0;
   logic [AW-1:0] seen_addr;
   logic [3:0]    seen_be;
   logic          seen_we;
   logic [WW-1:0] seen_wdata;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic finish_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   endtask

   function automatic logic [31:0] init_word(input int w);
      logic [31:0] wl;
      wl = 32'(w);
      return (wl * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   function automatic logic [7:0] get_byte(input int off);
      logic [31:0] w;
      if (model_mem.exists(off)) return model_mem[off];
      w = init_word(off >> 2);
      return w[8*(off % 4) +: 8];
   endfunction

   function automatic logic [31:0] resp_word(input int w);
      if (resp_mem.exists(w)) return resp_mem[w];
      return init_word(w);
   endfunction

   task automatic preload(input int w, input logic [31:0] val);
      resp_mem[w] = val;
      for (int i = 0; i < 4; i++) model_mem[w*4 + i] = val[8*i +: 8];
   endtask

   // Applies one instruction just after a rising edge and queues its expected retirement.
   task automatic drive(input bit rd, input bit wr, input bit wb, input logic [1:0] sz,
                        input bit sx, input logic [31:0] addr, input logic [31:0] val,
                        input int dly);
      exp_t        e;
      longint      off;
      int          n;
      bit          acc, err, valid, tmo;
      logic [31:0] v;
      #1;
      mem_read = rd; mem_write = wr; WB_en = wb; size = sz; sign_ext = sx;
      ALU_res = addr; val_Rm = val; dst = RD'($urandom()); ack_delay = dly;
      n     = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      off   = longint'(addr) - longint'(BASE);
      acc   = rd | wr;
      err   = acc && (sz == 2'd3 || off < 0 || off >= (longint'(1) << (AW + 2)) ||
                      (off % longint'(n)) != 0);
      valid = acc && !err;
      tmo   = valid && !(dly >= 1 && dly <= TO);
      e = '{default: '0};
      e.dst = dst; e.alu = addr; e.valid = valid; e.err = err | tmo;
      e.wb  = wb & ~e.err; e.mrd = rd & ~e.err;
      if (valid) begin
         e.reqc  = tmo ? TO : dly;
         e.stall = 1 + e.reqc;
         e.addr  = AW'(off >> 2);
         e.we    = wr;
         for (int i = 0; i < n; i++) e.be[int'(off % 4) + i] = 1'b1;
         e.wdata = (n == 1) ? {4{val[7:0]}} : (n == 2) ? {2{val[15:0]}} : val;
         if (tmo) model_mem_out = '0;
         else if (wr) begin
            for (int i = 0; i < n; i++) model_mem[int'(off) + i] = val[8*i +: 8];
         end else begin
            v = '0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = get_byte(int'(off) + i);
            if (sx) for (int b = 8*n; b < 32; b++) v[b] = v[8*n - 1];
            model_mem_out = v;
         end
      end
      e.mem_out = model_mem_out;
      sb_q.push_back(e);
   endtask

   task automatic issue(input bit rd, input bit wr, input bit wb, input logic [1:0] sz,
                        input bit sx, input logic [31:0] addr, input logic [31:0] val,
                        input int dly);
      int start, c;
      drive(rd, wr, wb, sz, sx, addr, val, dly);
      start = retire_cnt;
      c = 0;
      do begin
         @(posedge clk);
         c++;
      end while (retire_cnt == start && c < 40);
      if (retire_cnt == start) begin
         chk("retire_timeout", 64'(retire_cnt), 64'(start + 1));
         finish_run();
      end
   endtask

   // External memory: acks on the requested BUSY cycle, otherwise idles with junk.
   initial begin
      int          cnt;
      logic [31:0] w;
      cnt = 0;
      ext.ack = 1'b0;
      ext.rdata = '0;
      forever begin
         @(negedge clk);
         ext.ack = 1'b0;
         ext.rdata = $urandom();
         if (ext.req && rst) begin
            cnt++;
            if (cnt == 1) begin
               seen_addr = ext.addr; seen_be = ext.be; seen_we = ext.we;
               seen_wdata = ext.wdata; unstable = 1'b0;
            end else if (ext.addr !== seen_addr || ext.be !== seen_be ||
                         ext.we !== seen_we || ext.wdata !== seen_wdata) begin
               unstable = 1'b1;
            end
            if (cnt == ack_delay) begin
               w = resp_word(int'(ext.addr));
               if (ext.we) begin
                  for (int i = 0; i < 4; i++) if (ext.be[i]) w[8*i +: 8] = ext.wdata[8*i +: 8];
                  resp_mem[int'(ext.addr)] = w;
               end else begin
                  ext.rdata = w;
               end
               ext.ack = 1'b1;
            end
         end else begin
            cnt = 0;
            ext.ack = force_ack | ($urandom_range(0, 7) == 0);
         end
      end
   end

   // Monitor: every unfrozen cycle retires exactly one instruction.
   initial begin
      int   fcnt, rcnt;
      exp_t e;
      fcnt = 0;
      rcnt = 0;
      forever begin
         @(negedge clk);
         if (!mon_en || !rst) begin
            fcnt = 0;
            rcnt = 0;
         end else if (freeze) begin
            fcnt++;
            if (ext.req) rcnt++;
            chk("wb_gated", 64'(WB_en_out), 64'(0));
            chk("mrd_gated", 64'(mem_read_out), 64'(0));
         end else begin
            if (sb_q.size() == 0) begin
               chk("unexpected_retire", 64'(1), 64'(0));
            end else begin
               e = sb_q.pop_front();
               chk("access_err", 64'(access_err), 64'(e.err));
               chk("wb_en_out", 64'(WB_en_out), 64'(e.wb));
               chk("mem_read_out", 64'(mem_read_out), 64'(e.mrd));
               chk("mem_out", 64'(mem_out), 64'(e.mem_out));
               chk("stall_cycles", 64'(fcnt), 64'(e.stall));
               chk("req_cycles", 64'(rcnt), 64'(e.reqc));
               chk("dst_out", 64'(dst_out), 64'(e.dst));
               chk("alu_res_out", 64'(ALU_res_out), 64'(e.alu));
               if (e.valid) begin
                  chk("ext_addr", 64'(seen_addr), 64'(e.addr));
                  chk("ext_be", 64'(seen_be), 64'(e.be));
                  chk("ext_we", 64'(seen_we), 64'(e.we));
                  chk("ext_wdata", 64'(seen_wdata), 64'(e.wdata));
                  chk("req_stable", 64'(unstable), 64'(0));
               end
            end
            fcnt = 0;
            rcnt = 0;
            retire_cnt++;
         end
      end
   end

   initial begin
      #2000000;
      chk("watchdog", 64'(1), 64'(0));
      finish_run();
   end

   initial begin
      // Reset: outputs cleared and stall/error forced low even with a valid access present.
      mem_read = 1'b1; size = 2'd2; ALU_res = 32'd1028;
      @(negedge clk); @(negedge clk);
      chk("rst_req", 64'(ext.req), 64'(0));
      chk("rst_we", 64'(ext.we), 64'(0));
      chk("rst_addr", 64'(ext.addr), 64'(0));
      chk("rst_be", 64'(ext.be), 64'(0));
      chk("rst_wdata", 64'(ext.wdata), 64'(0));
      chk("rst_mem_out", 64'(mem_out), 64'(0));
      chk("rst_freeze", 64'(freeze), 64'(0));
      chk("rst_access_err", 64'(access_err), 64'(0));
      mem_read = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      mon_en = 1'b1;

      preload(1, 32'hDEADBEEF);
      preload(0, 32'h80FF1234);
      issue(1, 0, 1, 2'd2, 0, 32'd1028, 32'h0, 1);
      chk("plan_word_load", 64'(mem_out), 64'hDEADBEEF);
      issue(1, 0, 1, 2'd0, 1, 32'd1027, 32'h0, 1);
      chk("plan_byte_sext", 64'(mem_out), 64'hFFFFFF80);
      issue(1, 0, 1, 2'd0, 0, 32'd1027, 32'h0, 2);
      chk("plan_byte_zext", 64'(mem_out), 64'h00000080);
      issue(0, 1, 0, 2'd1, 0, 32'd1026, 32'h1234ABCD, 3);
      chk("plan_half_wdata", 64'(ext.wdata), 64'hABCDABCD);
      chk("plan_half_be", 64'(ext.be), 64'hC);
      issue(1, 0, 1, 2'd2, 0, 32'd1025, 32'h0, 1);
      issue(1, 0, 1, 2'd0, 0, 32'd1000, 32'h0, 1);
      issue(1, 0, 1, 2'd3, 0, 32'd1028, 32'h0, 1);
      issue(1, 0, 1, 2'd2, 0, 32'd1028, 32'h0, 0);
      issue(1, 0, 1, 2'd2, 0, 32'd1024, 32'h0, TO);
      issue(0, 0, 1, 2'd0, 0, 32'd5, 32'h0, 1);

      // Reset in the middle of a BUSY access.
      mon_en = 1'b0;
      #1;
      mem_read = 1'b1; mem_write = 1'b0; size = 2'd2; ALU_res = 32'd1028; ack_delay = 0;
      @(posedge clk);
      @(posedge clk); #1;
      chk("mid_busy_req", 64'(ext.req), 64'(1));
      rst = 1'b0;
      #1;
      chk("abort_req", 64'(ext.req), 64'(0));
      chk("abort_mem_out", 64'(mem_out), 64'(0));
      chk("abort_freeze", 64'(freeze), 64'(0));
      mem_read = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      force_ack = 1'b1;
      @(posedge clk); #1;
      force_ack = 1'b0;
      chk("late_ack_mem_out", 64'(mem_out), 64'(0));
      chk("late_ack_req", 64'(ext.req), 64'(0));
      chk("late_ack_freeze", 64'(freeze), 64'(0));
      sb_q.delete();
      model_mem_out = '0;
      mon_en = 1'b1;
      issue(1, 0, 1, 2'd2, 0, 32'd1032, 32'h0, 2);

      for (int t = 0; t < 250; t++) begin
         logic [31:0] a;
         logic [1:0]  sz;
         int          r;
         r  = $urandom_range(0, 9);
         sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         if (r < 8) begin
            a = BASE + $urandom_range(0, 63);
            if ($urandom_range(0, 3) != 0) begin
               if (sz == 2'd1) a[0] = 1'b0;
               if (sz == 2'd2) a[1:0] = 2'b00;
            end
         end else if (r == 8) begin
            a = $urandom_range(0, BASE - 1);
         end else begin
            a = BASE + (32'd1 << (AW + 2)) + $urandom_range(0, 255);
         end
         issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               sz, 1'($urandom_range(0, 1)), a, $urandom(), $urandom_range(0, 6));
      end
      mon_en = 1'b0;
      finish_run();
   end
endmodule
